fft_twiddle_seq: RTL
====================

# fft_twiddle_seq

Parametrised per-stage control sequencer and twiddle ROM for a radix-2 single-path delay-feedback (SDF) DIF FFT pipeline; one instance sits beside each butterfly stage. It tracks the position of the sample presented on the stage input and tells the stage datapath which phase it is in: prime, fill, or butterfly. During butterfly phase it supplies the matching fixed-point twiddle factor W = exp(∓j·π·k/L). It generalises the fixed 2-entry stage controller to any FFT size, any stage index, any twiddle width, and forward/inverse mode, with clean valid-gated stalls and a synchronous restart.

## Interface
- N_LOG2, 9, log2 of FFT size N (N=512 default); legal 2..12
- STAGE, 0, stage index, 0..N_LOG2-1; half-block length L = 2^(N_LOG2-STAGE-1)
- W, 24, twiddle word width, two's complement
- FRAC, 8, fractional bits of twiddle words (1.0 = 2^FRAC); W > FRAC+1
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  sample presented this cycle is accepted; advances sequencer
- clr  in  1  synchronous restart to frame start, re-enter prime
- inv  in  1  1 = inverse FFT (positive imaginary twiddle sign); captured only at clr or reset-release
- state  out  2  0 PRIME, 1 FILL, 2 BFLY; 3 never driven
- w_r  out  W  twiddle real part
- w_i  out  W  twiddle imaginary part
- tw_idx  out  N_LOG2-1  twiddle index k (0 outside BFLY)
- blk_last  out  1  current sample is last of a 2L block
- frm_last  out  1  current sample is last of an N-sample frame

## Operation
- Sample counter cnt, N_LOG2 bits, wraps N-1 -> 0; block index idx = cnt mod 2L.
- primed flag: cleared by reset/clr, set on the acceptance of the sample with idx = L-1.
- All outputs are a function of the registered cnt, primed, and mode. They describe the sample currently presented, Moore-style.
- State decode:
  - idx < L and !primed -> PRIME: delay line empty; stage output is invalid.
  - idx < L and primed -> FILL: delay line drains the twiddle-multiplied difference.
  - idx >= L -> BFLY.
- Transitions: PRIME -> BFLY at idx L; BFLY -> FILL at block wrap; FILL -> BFLY at idx L. PRIME is never re-entered except via reset/clr.
- Twiddle in BFLY: k = idx - L.
  - w_r = round(cos(π·k/L)·2^FRAC).
  - w_i = ∓round(sin(π·k/L)·2^FRAC): minus when mode=0, plus when mode=1.
  - Rounding is to nearest, ties away from zero.
  - Results are sign-extended to W.
  - The table is elaborated at compile time: L entries, or quarter-wave with symmetry. Bit-exact results are required either way.
- Outside BFLY: w_r = 2^FRAC, w_i = 0, tw_idx = 0.
- Last stage (L=1): BFLY k is always 0, so w = 1.0.
- blk_last = (idx == 2L-1); frm_last = (cnt == N-1).
- mode register: loaded from inv on clr and at reset-release (reset value 0). inv is ignored otherwise.

## Timing
- Reset (async assert): cnt=0, primed=0, mode=0. Resulting outputs: state=0, w_r=2^FRAC, w_i=0, tw_idx=0, blk_last=0, frm_last=0.
- Zero latency: outputs valid in the same cycle as the sample they describe. Combinational depth covers decode/ROM only; no path from in_valid to any output.
- in_valid=0: all registers hold, and outputs are stable indefinitely (stall).
- Edge with in_valid=1: cnt increments, primed updates, and outputs change to describe the next sample.
- clr=1: overrides in_valid on that edge. cnt=0, primed=0, mode=inv. The sample presented with clr is not counted.
- Reset mid-frame: immediate return to reset values; no partial-frame state survives.
- Wrap at N-1 is seamless: the next frame starts in FILL (primed stays 1), not PRIME.

## Test plan
- N_LOG2=3, STAGE=1 (L=2), 8 consecutive valids from reset -> state 0,0,2,2,1,1,2,2. The BFLY pairs give (w_r,w_i) = (256,0),(0,-256). blk_last high on samples 3 and 7; frm_last high on sample 7.
- N_LOG2=3, STAGE=0 (L=4), W=24, FRAC=8 -> BFLY k=0..3 gives (256,0),(181,-181),(0,-256),(-181,-181). tw_idx = 0,1,2,3.
- Same config with inv=1 at clr -> w_i values 0,181,256,181. Holding inv=0 afterwards without clr keeps the sign positive.
- Random in_valid gaps (≥30% idle) over 3 frames of N=512, STAGE=4 -> output sequence indexed by accepted sample matches a golden model, and outputs are unchanged on every idle cycle.
- clr asserted at cnt=5 with in_valid=1 -> next cycle cnt=0, state=0, w=(256,0). Re-priming takes L accepted samples.
- rst_n pulsed low mid-BFLY (N_LOG2=9, STAGE=0, k=100) -> outputs are reset values asynchronously. After release, the first 256 accepted samples show state=0.

Source files
------------

// File: rtl/fft_twiddle_seq.sv
// rtl/fft_twiddle_seq.sv - per-stage SDF radix-2 DIF sequencer and twiddle ROM
module fft_twiddle_seq #(
  parameter int N_LOG2 = 9,
  parameter int STAGE  = 0,
  parameter int W      = 24,
  parameter int FRAC   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic                clr,
  input  logic                inv,
  output logic [1:0]          state,
  output logic signed [W-1:0] w_r,
  output logic signed [W-1:0] w_i,
  output logic [N_LOG2-2:0]   tw_idx,
  output logic                blk_last,
  output logic                frm_last
);

  localparam int  LB = N_LOG2 - STAGE - 1;
  localparam int  L  = 1 << LB;
  localparam int  IW = LB + 1;
  localparam int  KW = N_LOG2 - 1;
  localparam real PI = 3.14159265358979323846;

  typedef enum logic [1:0] {PRIME = 2'd0, FILL = 2'd1, BFLY = 2'd2} phase_t;
  typedef logic signed [W-1:0] tw_t;

  // Nearest, ties away from zero; the small bias absorbs libm error on exact ties.
  function automatic int tw_round(input real x);
    real a;
    a = (x < 0.0) ? -x : x;
    a = $floor(a + 0.5 + 1.0e-9);
    return (x < 0.0) ? -int'(a) : int'(a);
  endfunction

  logic [N_LOG2-1:0] cnt;
  logic              primed;
  logic              mode;
  logic              mode_loaded;

  logic [IW-1:0]     idx;
  logic [IW-1:0]     k_raw;
  logic              in_bfly;
  phase_t            phase;
  tw_t               sin_mag;

  // Indexed by block position directly: the lower half holds the 1.0 / 0 idle value.
  tw_t rom_c [2*L];
  tw_t rom_s [2*L];

  for (genvar g = 0; g < 2*L; g++) begin : g_rom
    if (g < L) begin : g_idle
      assign rom_c[g] = tw_t'(1 << FRAC);
      assign rom_s[g] = '0;
    end else begin : g_tw
      localparam int C = tw_round($cos(PI * real'(g - L) / real'(L)) * real'(1 << FRAC));
      localparam int S = tw_round($sin(PI * real'(g - L) / real'(L)) * real'(1 << FRAC));
      assign rom_c[g] = tw_t'(C);
      assign rom_s[g] = tw_t'(S);
    end
  end

  assign idx     = cnt[IW-1:0];
  assign in_bfly = idx[IW-1];
  assign k_raw   = idx - IW'(L);

  always_comb begin
    phase = PRIME;
    if (in_bfly)     phase = BFLY;
    else if (primed) phase = FILL;
  end

  assign state    = phase;
  assign sin_mag  = rom_s[idx];
  assign w_r      = rom_c[idx];
  assign w_i      = mode ? sin_mag : -sin_mag;
  assign tw_idx   = in_bfly ? KW'(k_raw) : '0;
  assign blk_last = &idx;
  assign frm_last = &cnt;

  // mode_loaded marks the first edge after reset release, where inv is sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      primed      <= 1'b0;
      mode        <= 1'b0;
      mode_loaded <= 1'b0;
    end else begin
      mode_loaded <= 1'b1;
      if (!mode_loaded) mode <= inv;
      if (clr) begin
        cnt    <= '0;
        primed <= 1'b0;
        mode   <= inv;
      end else if (in_valid) begin
        cnt <= cnt + N_LOG2'(1);
        if (idx == IW'(L - 1)) primed <= 1'b1;
      end
    end
  end

endmodule
